// File: rtl/mag_cmp_pipe.sv
// Pipelined magnitude comparator: one SLICE-bit chunk per stage, MSB chunk first.
// Each stage carries a running EQ/GT/LT verdict and only the operand bits still
// to be compared. Valid/ready handshake with full back-pressure: a stalled
// output freezes the whole pipeline, bubbles included.
// Optional feature macro: MAG_CMP_SIGNED_EN adds the signed_mode port, which
// travels with each pair and selects two's-complement ordering.
module mag_cmp_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MAG_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_greater_b,
  output logic             a_lesser_b,
  output logic             a_equal_b
);

  localparam int unsigned STAGES = WIDTH / SLICE;

  typedef enum logic [1:0] {
    V_EQ = 2'd0,
    V_GT = 2'd1,
    V_LT = 2'd2
  } verd_e;

  // A resolved verdict is sticky; only an EQ verdict looks at the current slice.
  function automatic verd_e verd_step(input verd_e vin,
                                      input logic [SLICE-1:0] sa,
                                      input logic [SLICE-1:0] sb);
    verd_e v;
    v = vin;
    if (vin == V_EQ) begin
      if (sa > sb)      v = V_GT;
      else if (sa < sb) v = V_LT;
      else              v = V_EQ;
    end
    return v;
  endfunction

  logic stall_c;
  logic sm_c;
  logic out_valid_q;
  logic gt_q;
  logic lt_q;
  logic eq_q;

`ifdef MAG_CMP_SIGNED_EN
  assign sm_c = signed_mode;
`else
  assign sm_c = 1'b0;
`endif

  assign stall_c  = out_valid_q && !out_ready;
  assign in_ready = !stall_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still to be compared at the input of stage k
    localparam int unsigned WK = WIDTH - k * SLICE;

    logic             vld_q;
    logic [WK-1:0]    a_q;
    logic [WK-1:0]    b_q;
    verd_e            vin_c;
    verd_e            vout_c;
    logic [SLICE-1:0] sa_c;
    logic [SLICE-1:0] sb_c;

    if (k == 0) begin : g_first
      logic sm_q;

      // Capture an accepted pair; a stall holds the stage, bubble or not
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (!stall_c) begin
          vld_q <= in_valid;
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            sm_q <= sm_c;
          end
        end
      end

      // Top slice, MSB flipped in signed mode so offset-binary order applies
      always_comb begin
        logic [SLICE-1:0] msk;
        msk              = '0;
        msk[SLICE-1]     = sm_q;
        vin_c            = V_EQ;
        sa_c             = a_q[WK-1 -: SLICE] ^ msk;
        sb_c             = b_q[WK-1 -: SLICE] ^ msk;
      end
    end else begin : g_next
      verd_e vin_q;

      // Advance the previous stage's verdict and its untouched lower bits
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (!stall_c) begin
          vld_q <= g_stg[k-1].vld_q;
          vin_q <= g_stg[k-1].vout_c;
          a_q   <= g_stg[k-1].a_q[WK-1:0];
          b_q   <= g_stg[k-1].b_q[WK-1:0];
        end
      end

      // Compare this stage's top slice against the carried verdict
      always_comb begin
        vin_c = vin_q;
        sa_c  = a_q[WK-1 -: SLICE];
        sb_c  = b_q[WK-1 -: SLICE];
      end
    end

    assign vout_c = verd_step(vin_c, sa_c, sb_c);
  end

  // Registered result flags; all zero whenever no result is presented
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else if (!stall_c) begin
      out_valid_q <= g_stg[STAGES-1].vld_q;
      gt_q        <= g_stg[STAGES-1].vld_q && (g_stg[STAGES-1].vout_c == V_GT);
      lt_q        <= g_stg[STAGES-1].vld_q && (g_stg[STAGES-1].vout_c == V_LT);
      eq_q        <= g_stg[STAGES-1].vld_q && (g_stg[STAGES-1].vout_c == V_EQ);
    end
  end

  assign out_valid   = out_valid_q;
  assign a_greater_b = gt_q;
  assign a_lesser_b  = lt_q;
  assign a_equal_b   = eq_q;

endmodule

// File: tb/tb_mag_cmp_pipe.sv
// Bench for mag_cmp_pipe (WIDTH=16, SLICE=4): directed steps plus a random
// stream scored against an arithmetic reference model.
module tb_mag_cmp_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             a_greater_b;
  logic             a_lesser_b;
  logic             a_equal_b;

  mag_cmp_pipe #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
`ifdef MAG_CMP_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_greater_b (a_greater_b),
    .a_lesser_b  (a_lesser_b),
    .a_equal_b   (a_equal_b)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  int         pops = 0;
  logic [2:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [3:0] prev_out = '0;
  logic       last_acc = 1'b0;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference ordering from plain integer arithmetic: {gt, lt, eq}
  function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y, input logic sm);
    longint ix;
    longint iy;
    ix = sm ? longint'($signed(x)) : longint'(x);
    iy = sm ? longint'($signed(y)) : longint'(y);
    return {ix > iy, ix < iy, ix == iy};
  endfunction

  // One clock: drive at negedge, sample 1ns later, score, then let the posedge happen
  task automatic step(input logic r, input logic iv, input logic [15:0] av,
                      input logic [15:0] bv, input logic sm, input logic ordy);
    logic [3:0] o;
    logic       smx;
`ifdef MAG_CMP_SIGNED_EN
    smx = sm;
`else
    smx = 1'b0;
`endif
    @(negedge clk);
    rst         = r;
    in_valid    = iv;
    a           = av;
    b           = bv;
    signed_mode = smx;
    out_ready   = ordy;
    #1;
    o = {out_valid, a_greater_b, a_lesser_b, a_equal_b};
    chk("in_ready_rule", 16'(in_ready), 16'(!(out_valid && !ordy)));
    if (out_valid) chk("flags_onehot", 16'($countones(o[2:0])), 16'd1);
    else           chk("flags_idle", 16'(o[2:0]), 16'd0);
    if (prev_stall) chk("stall_hold", 16'(o), 16'(prev_out));
    if (out_valid && ordy && !r) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 16'(o), 16'd0);
      end else begin
        chk("result", 16'(o[2:0]), 16'(exp_q.pop_front()));
        pops++;
      end
    end
    last_acc = iv && in_ready && !r;
    if (last_acc) exp_q.push_back(model(av, bv, smx));
    prev_stall = out_valid && !ordy && !r;
    prev_out   = o;
    if (r) exp_q.delete();
  endtask

  initial begin
    logic [15:0] sa[4];
    logic [15:0] sb[4];
    logic [2:0]  sexp[4];
    int          p0;
    int          acc;
    int          cyc;
    logic        pv;
    logic [15:0] pa;
    logic [15:0] pb;
    logic        psm;

    sa   = '{16'h8000, 16'h0001, 16'h00F0, 16'hFFFF};
    sb   = '{16'h7FFF, 16'h0002, 16'h00F0, 16'hFFFE};
    sexp = '{F_GT, F_LT, F_EQ, F_GT};

    // Reset state
    repeat (3) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_flags", 16'({a_greater_b, a_lesser_b, a_equal_b}), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);

    // Single pair: result exactly four edges after the accepting edge
    p0 = pops;
    step(1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      chk("latency_valid", 16'(out_valid), 16'(i == 5));
      if (i == 5) chk("latency_eq", 16'({a_greater_b, a_lesser_b, a_equal_b}), 16'(F_EQ));
    end
    chk("single_count", 16'(pops - p0), 16'd1);

    // Back-to-back stream, one result per cycle in order
    p0 = pops;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, sa[i], sb[i], 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      chk("stream_valid", 16'(out_valid), 16'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5)
        chk("stream_flags", 16'({a_greater_b, a_lesser_b, a_equal_b}), 16'(sexp[i-2]));
    end
    chk("stream_count", 16'(pops - p0), 16'd4);

    // Same stream with a 3-cycle consumer stall on the first result; a new
    // pair offered during the stall must wait and be accepted exactly once
    p0 = pops;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, sa[i], sb[i], 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
      chk("stall_in_ready", 16'(in_ready), 16'd0);
      chk("stall_flags", 16'({out_valid, a_greater_b, a_lesser_b, a_equal_b}), 16'({1'b1, F_GT}));
    end
    step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("stall_release_accept", 16'(last_acc), 16'd1);
    repeat (10) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("stall_count", 16'(pops - p0), 16'd5);
    chk("stall_drained", 16'(exp_q.size()), 16'd0);

    // Reset with three pairs in flight: nothing may come out afterwards
    p0 = pops;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, sa[i], sb[i], 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_flags", 16'({a_greater_b, a_lesser_b, a_equal_b}), 16'd0);
    repeat (8) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("midrst_no_results", 16'(pops - p0), 16'd0);

    // Boundaries: all-zero, all-ones, LSB-only and MSB-only differences
    p0 = pops;
    step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("boundary_count", 16'(pops - p0), 16'd6);

`ifdef MAG_CMP_SIGNED_EN
    // Signed ordering follows signed_mode of each individual pair
    p0 = pops;
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (i == 3) chk("signed_neg_vs_pos", 16'({a_greater_b, a_lesser_b, a_equal_b}), 16'(F_LT));
      if (i == 4) chk("unsigned_same_pair", 16'({a_greater_b, a_lesser_b, a_equal_b}), 16'(F_GT));
      if (i == 5) chk("signed_m1_vs_m2", 16'({a_greater_b, a_lesser_b, a_equal_b}), 16'(F_GT));
    end
    chk("signed_count", 16'(pops - p0), 16'd3);
`endif

    // Random stream with random handshakes; producer holds a pair until taken
    acc = 0;
    cyc = 0;
    pv  = 1'b0;
    pa  = '0;
    pb  = '0;
    psm = 1'b0;
    while (acc < 10000 && cyc < 60000) begin
      if (!pv && ($urandom_range(0, 9) < 7)) begin
        pv  = 1'b1;
        pa  = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       pb = pa;
          1:       pb = pa ^ (16'h1 << $urandom_range(0, 15));
          default: pb = 16'($urandom);
        endcase
        psm = 1'($urandom_range(0, 1));
      end
      step(1'b0, pv, pa, pb, psm, 1'($urandom_range(0, 9) < 7));
      if (last_acc) begin
        pv = 1'b0;
        acc++;
      end
      cyc++;
    end
    chk("random_accepted", 16'(acc), 16'd10000);
    repeat (12) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("random_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
